uio_bus_arbiter: RTL and testbench

- Shares the tile's 8-bit bidirectional uio pin bank between N_REQ internal requesters, for example a debug port, a data streamer and a config loader.
- Grants the bank round-robin to one requester at a time. Only the granted requester's uio_out/uio_oe values reach the pins.
- Inserts turnaround cycles with all pins tristated between owners so two drivers never overlap.
- Sits between the requester blocks and the top-level uio_out/uio_oe outputs.

---
 rtl/uio_arb_pkg.sv | 21 ++
 rtl/uio_bus_arbiter_rr_pick.sv | 34 +++
 rtl/uio_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_uio_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uio_arb_pkg.sv
// Shared types and helpers for the uio pin-bank arbiter and related tile arbiters.
package uio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam int MAX_REQ = 8;

    // Owner index width, never narrower than one bit.
    function automatic int own_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Round-robin pick: first set req bit searching from ptr upward with wrap.
// Purely combinational; no latency, no backpressure.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [2*N-1:0] dbl;
    int             s;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        s     = 0;
        // Rotating a doubled copy puts candidate ptr at bit 0.
        dbl   = {req, req} >> ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && dbl[k]) begin
                found = 1'b1;
                s     = int'(ptr) + k;
                if (s >= N) begin
                    s = s - N;
                end
                idx   = W'(s);
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pin bank with tristate turnaround between owners.
// Grant registered one edge after request; owner held until release, req drop or hold limit.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int MAX_HOLD  = 16,
    parameter  int TA_CYCLES = 1,
    localparam int OWN_W     = own_width(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   rel,
    input  logic [8*N_REQ-1:0] dout,
    input  logic [8*N_REQ-1:0] doe,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         uio_out,
    output logic [7:0]         uio_oe,
    output logic               busy,
    output logic [OWN_W-1:0]   owner
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    grant_d;
    logic                busy_d;
    logic [OWN_W-1:0]    owner_d;
    logic [OWN_W-1:0]    ptr_q, ptr_d, ptr_inc;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [1:0]          ta_q, ta_d;
    logic                pick_found;
    logic [OWN_W-1:0]    pick_idx;
    logic [MAX_REQ-1:0]  pick_oh;

    rr_pick #(
        .N (N_REQ),
        .W (OWN_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign ptr_inc = (owner_q_is_last()) ? '0 : owner + 1'b1;

    function automatic logic owner_q_is_last();
        return owner == OWN_W'(N_REQ - 1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant   <= '0;
            busy    <= 1'b0;
            owner   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            ta_q    <= '0;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
            busy    <= busy_d;
            owner   <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            ta_q    <= ta_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant;
        busy_d  = busy;
        owner_d = owner;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        ta_d    = ta_q;
        pick_oh = onehot(3'(pick_idx));
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    grant_d = pick_oh[N_REQ-1:0];
                    busy_d  = 1'b1;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (hold_q != HOLD_W'(MAX_HOLD)) begin
                    hold_d = hold_q + 1'b1;
                end
                // Voluntary release, dropped request and hold limit all end the grant alike.
                if (rel[owner] || !req[owner] || hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_inc;
                    if (TA_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = TURN;
                        ta_d    = 2'(TA_CYCLES);
                    end
                end
            end
            TURN: begin
                ta_d = ta_q - 1'b1;
                if (ta_q <= 2'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pins follow the registered owner only while granted; tristated otherwise.
    always_comb begin
        uio_out = '0;
        uio_oe  = '0;
        if (state_q == GRANT) begin
            uio_out = dout[{owner, 3'b000} +: 8];
            uio_oe  = doe[{owner, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter with N_REQ=4, MAX_HOLD=16, TA_CYCLES=1.
module tb_uio_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  rel;
    logic [31:0] dout;
    logic [31:0] doe;
    logic [3:0]  grant;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic        busy;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_pass   = 0;

    uio_bus_arbiter #(
        .N_REQ     (4),
        .MAX_HOLD  (16),
        .TA_CYCLES (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .dout    (dout),
        .doe     (doe),
        .grant   (grant),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .busy    (busy),
        .owner   (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "bench timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_pins;
        for (int i = 0; i < 4; i++) begin
            dout[8*i +: 8] = 8'hA0 + 8'(i);
            doe[8*i +: 8]  = 8'h30 + 8'(i);
        end
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        req = 4'b0000;
        rel = 4'b0000;
        set_default_pins();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = 4'b1111;
        rel = 4'b0000;
        tick();
        tick();
        n_checks++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b required %b", grant, 4'b0000); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
        n_checks++; if (uio_oe !== 8'h00) $display("FAIL reset_oe: got %h required 00", uio_oe); else n_pass++;
        n_checks++; if (owner !== 2'd0) $display("FAIL reset_owner: got %0d required 0", owner); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (grant !== 4'b0001) $display("FAIL reset_first_grant: got %b required %b", grant, 4'b0001); else n_pass++;
        n_checks++; if (uio_oe !== 8'h30) $display("FAIL reset_first_oe: got %h required 30", uio_oe); else n_pass++;
        n_checks++; if (uio_out !== 8'hA0) $display("FAIL reset_first_out: got %h required a0", uio_out); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (uio_oe !== 8'h00) $display("FAIL reset_async_oe: got %h required 00", uio_oe); else n_pass++;
        n_checks++; if (grant !== 4'b0000) $display("FAIL reset_async_grant: got %b required 0000", grant); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_async_busy: got %b required 0", busy); else n_pass++;
        tick();
        rst = 1'b0;
        req = 4'b0000;
    endtask

    task automatic test_single;
        apply_reset();
        req = 4'b0100;
        tick();
        n_checks++; if (grant !== 4'b0100) $display("FAIL single_grant: got %b required 0100", grant); else n_pass++;
        n_checks++; if (owner !== 2'd2) $display("FAIL single_owner: got %0d required 2", owner); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b required 1", busy); else n_pass++;
        n_checks++; if (uio_out !== 8'hA2) $display("FAIL single_out: got %h required a2", uio_out); else n_pass++;
        n_checks++; if (uio_oe !== 8'h32) $display("FAIL single_oe: got %h required 32", uio_oe); else n_pass++;
        rel = 4'b0100;
        tick();
        rel = 4'b0000;
        n_checks++; if (grant !== 4'b0000) $display("FAIL single_rel_grant: got %b required 0000", grant); else n_pass++;
        n_checks++; if (uio_oe !== 8'h00) $display("FAIL single_turn_oe: got %h required 00", uio_oe); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_turn_busy: got %b required 0", busy); else n_pass++;
        tick();
        n_checks++; if (grant !== 4'b0000) $display("FAIL single_idle_grant: got %b required 0000", grant); else n_pass++;
        n_checks++; if (uio_oe !== 8'h00) $display("FAIL single_idle_oe: got %h required 00", uio_oe); else n_pass++;
        tick();
        n_checks++; if (grant !== 4'b0100) $display("FAIL single_regrant: got %b required 0100", grant); else n_pass++;
        req = 4'b0000;
        tick();
        n_checks++; if (grant !== 4'b0000) $display("FAIL single_reqdrop: got %b required 0000", grant); else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_round_robin;
        logic [3:0] eg;
        logic [7:0] eo;
        int         gap;
        apply_reset();
        req = 4'b1111;
        tick();
        for (int n = 0; n < 5; n++) begin
            eg = 4'b0001 << (n % 4);
            eo = 8'h30 + 8'(n % 4);
            n_checks++; if (grant !== eg) $display("FAIL rr_order_%0d: got %b required %b", n, grant, eg); else n_pass++;
            n_checks++; if (uio_oe !== eo) $display("FAIL rr_oe_%0d: got %h required %h", n, uio_oe, eo); else n_pass++;
            tick();
            tick();
            rel = eg;
            tick();
            rel = 4'b0000;
            gap = 0;
            while (grant === 4'b0000 && gap < 10) begin
                n_checks++; if (uio_oe !== 8'h00) $display("FAIL rr_gap_oe_%0d: got %h required 00", n, uio_oe); else n_pass++;
                gap++;
                tick();
            end
            n_checks++; if (gap != 2) $display("FAIL rr_gap_len_%0d: got %0d required 2", n, gap); else n_pass++;
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_forced;
        int len;
        int gap;
        apply_reset();
        req = 4'b0010;
        tick();
        for (int r = 0; r < 2; r++) begin
            len = 0;
            while (grant === 4'b0010 && len < 40) begin
                n_checks++; if (uio_oe !== 8'h31) $display("FAIL forced_oe_%0d: got %h required 31", r, uio_oe); else n_pass++;
                len++;
                tick();
            end
            n_checks++; if (len != 16) $display("FAIL forced_len_%0d: got %0d required 16", r, len); else n_pass++;
            gap = 0;
            while (grant === 4'b0000 && gap < 10) begin
                n_checks++; if (uio_oe !== 8'h00) $display("FAIL forced_gap_oe_%0d: got %h required 00", r, uio_oe); else n_pass++;
                gap++;
                tick();
            end
            n_checks++; if (gap != 2) $display("FAIL forced_gap_%0d: got %0d required 2", r, gap); else n_pass++;
            n_checks++; if (grant !== 4'b0010) $display("FAIL forced_regrant_%0d: got %b required 0010", r, grant); else n_pass++;
        end
        req = 4'b0000;
        tick();
        tick();
        tick();
    endtask

    task automatic test_fairness;
        logic [1:0] eo;
        logic [3:0] eg;
        int         len;
        int         gap;
        apply_reset();
        req = 4'b1001;
        tick();
        for (int n = 0; n < 5; n++) begin
            eo = (n % 2 == 0) ? 2'd0 : 2'd3;
            eg = 4'b0001 << eo;
            n_checks++; if (owner !== eo || grant !== eg) $display("FAIL fair_owner_%0d: got %0d/%b required %0d/%b", n, owner, grant, eo, eg); else n_pass++;
            len = 0;
            while (grant === eg && len < 40) begin
                len++;
                tick();
            end
            n_checks++; if (len != 16) $display("FAIL fair_len_%0d: got %0d required 16", n, len); else n_pass++;
            gap = 0;
            while (grant === 4'b0000 && gap < 10) begin
                gap++;
                tick();
            end
            n_checks++; if (len + gap > 18) $display("FAIL fair_wait_%0d: got %0d required <=18", n, len + gap); else n_pass++;
        end
        req = 4'b0000;
        tick();
        tick();
        tick();
    endtask

    task automatic test_mux_isolation;
        logic [7:0] junk;
        apply_reset();
        dout[15:8] = 8'h5A;
        doe[15:8]  = 8'h0F;
        req = 4'b0010;
        tick();
        for (int k = 0; k < 4; k++) begin
            junk = (k % 2 == 1) ? 8'hFF : 8'h00;
            doe[7:0]   = junk;
            doe[23:16] = junk;
            doe[31:24] = junk;
            dout[7:0]  = ~junk;
            rel = 4'b1101;
            tick();
            n_checks++; if (uio_oe !== 8'h0F) $display("FAIL iso_oe_%0d: got %h required 0f", k, uio_oe); else n_pass++;
            n_checks++; if (uio_out !== 8'h5A) $display("FAIL iso_out_%0d: got %h required 5a", k, uio_out); else n_pass++;
            n_checks++; if (grant !== 4'b0010) $display("FAIL iso_grant_%0d: got %b required 0010", k, grant); else n_pass++;
        end
        rel = 4'b0000;
        req = 4'b0000;
        set_default_pins();
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        rel = 4'b0000;
        set_default_pins();
        test_reset();
        test_single();
        test_round_robin();
        test_forced();
        test_fairness();
        test_mux_isolation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
